demux_sched: RTL and testbench
==============================

DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-destination delivery counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_dest  input  2  destination index, used in directed mode.
REQ-009 SHALL have port mode  input  1  0 = round-robin, 1 = directed.
REQ-010 SHALL have port out_valid  output  4  one-hot valid, bit i for destination i.
REQ-011 SHALL have port out_ready  input  4  per-destination ready.
REQ-012 SHALL have port out_data  output  DATA_W  shared payload to all destinations.
REQ-013 SHALL have port sel  output  2  destination index of the held word, for driving a 2-to-4 demux select.
REQ-014 SHALL have port cnt_sel  input  2  counter read index.
REQ-015 SHALL have port cnt_out  output  CNT_W  delivered-word count of destination cnt_sel, combinational read.

Function
REQ-016 SHALL implement a two-state FSM:
- EMPTY: no word held.
- FULL: one word held in the output register.
REQ-017 Accept SHALL be defined as in_valid and in_ready both high.
REQ-018 Deliver SHALL be defined as FULL and out_ready[sel] high.
REQ-019 in_ready SHALL equal (state==EMPTY) or deliver, giving full throughput with a ready destination.
REQ-020 On accept, the block SHALL latch in_data into out_data and the chosen destination into sel, then enter or stay in FULL.
REQ-021 The chosen destination SHALL be in_dest when mode=1 and the round-robin pointer rr_ptr when mode=0.
REQ-022 mode SHALL be sampled only at accept; changing mode while FULL SHALL NOT alter the held sel.
REQ-023 rr_ptr SHALL advance by 1, wrapping 3->0, only on accept with mode=0; it SHALL hold otherwise, including in directed mode.
REQ-024 out_valid SHALL be one-hot at bit sel while FULL and 4'b0000 while EMPTY.
REQ-025 Deliver without accept SHALL move the FSM from FULL to EMPTY.
REQ-026 Simultaneous deliver and accept SHALL keep the FSM in FULL and load the new word with no bubble cycle.
REQ-027 While FULL and out_ready[sel]=0, out_data and sel SHALL remain stable, in_ready SHALL be 0, and out_ready on other bits SHALL be ignored.
REQ-028 Latency from accept to out_valid assertion SHALL be 1 cycle.
REQ-029 On each deliver, counter[sel] SHALL increment by 1, saturating at 2^CNT_W-1.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter EMPTY, and a held word SHALL be discarded without delivery.
REQ-031 Reset values SHALL be: rr_ptr=0, sel=0, out_data=0, all counters=0, out_valid=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Inputs present during reset SHALL be ignored.

Structure
REQ-034 A shared package demux_sched_pkg SHALL hold the FSM state enum (EMPTY, FULL), the mode encodings (MODE_RR=0, MODE_DIR=1) and the destination count constant NDEST=4.
REQ-035 The per-destination saturating counter SHALL be a sub-module sat_counter, instantiated four times.

Verification
REQ-036 Round-robin stream: mode=0, out_ready=4'hF, in_valid held high with data 0x11..0x18 -> sel sequence 0,1,2,3,0,1,2,3; one word per cycle; every counter reads 2.
REQ-037 Directed backpressure: mode=1, in_dest=2, data 0xA5, out_ready=4'b1011 -> out_valid=4'b0100 held and in_ready=0; after setting out_ready[2]=1, one deliver occurs and counter[2]=1.
REQ-038 Simultaneous deliver and accept: FULL with sel=1 and out_ready[1]=1, in_valid=1 with data 0x3C and mode=0 -> the next cycle is FULL with out_data=0x3C, sel=2 and no EMPTY cycle between.
REQ-039 Mode change while FULL: accept with mode=0 at rr_ptr=3, then set mode=1 with in_dest=0 before deliver -> sel stays 3 and rr_ptr becomes 0.
REQ-040 Reset mid-operation: FULL and stalled, pulse rst for 1 cycle -> out_valid=0, all counters=0, rr_ptr=0, in_ready=1, and the stalled word is never delivered.
REQ-041 Saturation: CNT_W=2, five delivers to destination 0 -> cnt_out with cnt_sel=0 reads 3.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux scheduler: FSM states, mode encodings,
// destination count and the select-to-one-hot helper.
package demux_sched_pkg;

  localparam int NDEST  = 4;
  localparam int DEST_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  function automatic logic [NDEST-1:0] dest_onehot(input logic [DEST_W-1:0] idx);
    logic [NDEST-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_sched_sat_counter.sv
// Per-destination delivery counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/demux_sched.sv
// One-word skid-free demux: holds a single word and presents it to one of four
// destinations chosen round-robin or by in_dest, with per-destination delivery counts.
module demux_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              mode,
  output logic [NDEST-1:0]  out_valid,
  input  logic [NDEST-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] sel,
  input  logic [DEST_W-1:0] cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DEST_W-1:0] r_sel;
  logic [DEST_W-1:0] r_rr_ptr;
  logic [DEST_W-1:0] w_dest;
  logic              w_deliver;
  logic              w_in_ready;
  logic              w_accept;
  logic [CNT_W-1:0]  w_cnt [NDEST];

  // Only the selected destination's ready matters; others are ignored while stalled.
  always_comb begin
    w_deliver   = (r_state == FULL) && out_ready[r_sel];
    w_in_ready  = (r_state == EMPTY) || w_deliver;
    w_accept    = in_valid && w_in_ready;
    w_dest      = (mode == MODE_DIR) ? in_dest : r_rr_ptr;
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = FULL;
    end else if (w_deliver) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // mode is consumed only here, so the held sel is immune to later mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_sel  <= w_dest;
      if (mode == MODE_RR) begin
        r_rr_ptr <= r_rr_ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NDEST; g++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .i_inc(w_deliver && (r_sel == DEST_W'(g))),
      .o_cnt(w_cnt[g])
    );
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == FULL) ? dest_onehot(r_sel) : '0;
  assign out_data  = r_data;
  assign sel       = r_sel;
  assign cnt_out   = w_cnt[cnt_sel];

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: directed scenarios plus a randomized run against a
// transaction-level model; a second instance with 2-bit counters covers saturation.
module tb_demux_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       mode;
  logic [3:0] out_ready;
  logic [1:0] cnt_sel;

  logic       in_ready, in_ready_s;
  logic [3:0] out_valid, out_valid_s;
  logic [7:0] out_data, out_data_s;
  logic [1:0] sel, sel_s;
  logic [7:0] cnt_out;
  logic [1:0] cnt_out_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_full;
  int         m_sel;
  logic [7:0] m_data;
  int         m_rr;
  int         m_cnt[4];
  int         m_cnt2[4];

  always #10 clk = ~clk;

  demux_sched #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  demux_sched #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_dest(in_dest), .mode(mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .sel(sel_s), .cnt_sel(cnt_sel), .cnt_out(cnt_out_s)
  );

  function automatic logic [3:0] exp_valid();
    return m_full ? (4'b0001 << m_sel) : 4'b0000;
  endfunction

  function automatic logic exp_ready();
    return !m_full || out_ready[m_sel];
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit dlv, acc;
    dlv = m_full && out_ready[m_sel];
    acc = in_valid && (!m_full || dlv);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_sel = 0; m_data = 8'h00; m_rr = 0;
      for (int d = 0; d < 4; d++) begin m_cnt[d] = 0; m_cnt2[d] = 0; end
    end else begin
      if (dlv) begin
        if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
        if (m_cnt2[m_sel] < 3) m_cnt2[m_sel]++;
      end
      if (acc) begin
        m_data = in_data;
        m_sel  = mode ? int'(in_dest) : m_rr;
        if (!mode) m_rr = (m_rr + 1) % 4;
        m_full = 1;
      end else if (dlv) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; in_data = 8'hEE; in_dest = 2'd3; mode = 1; out_ready = 4'hF;
    tick(); tick();
    rst = 0; in_valid = 0; mode = 0; in_dest = 0; in_data = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_data !== 8'h00 || sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_data_sel got %h/%0d want 00/0", out_data, sel);
    end
    for (int d = 0; d < 4; d++) begin
      cnt_sel = 2'(d); #1;
      n_checks++;
      if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL reset_cnt%0d got %0d want 0", d, cnt_out); end
    end
  endtask

  task automatic test_rr_stream();
    do_reset();
    mode = 0; out_ready = 4'hF; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h11 + 8'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_in_ready word %0d got %b want 1", i, in_ready); end
      tick();
      n_checks++;
      if (sel !== 2'(i % 4) || out_data !== 8'h11 + 8'(i) || out_valid !== (4'b0001 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_word%0d got sel=%0d data=%h valid=%b want sel=%0d data=%h", i, sel, out_data,
                 out_valid, i % 4, 8'h11 + 8'(i));
      end
    end
    in_valid = 0;
    tick();
    for (int d = 0; d < 4; d++) begin
      cnt_sel = 2'(d); #1;
      n_checks++;
      if (cnt_out !== 8'd2) begin n_fail++; $display("FAIL rr_cnt%0d got %0d want 2", d, cnt_out); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1; in_dest = 2; in_data = 8'hA5; out_ready = 4'b1011; in_valid = 1;
    tick();
    in_valid = 0; in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 4'b0100 || in_ready !== 1'b0 || out_data !== 8'hA5) begin
        n_fail++;
        $display("FAIL bp_stall%0d got valid=%b ready=%b data=%h want 0100/0/a5", i, out_valid, in_ready, out_data);
      end
      tick();
    end
    out_ready = 4'b0100;
    tick();
    n_checks++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drain got valid=%b want 0000", out_valid); end
    for (int d = 0; d < 4; d++) begin
      cnt_sel = 2'(d); #1;
      n_checks++;
      if (cnt_out !== ((d == 2) ? 8'd1 : 8'd0)) begin
        n_fail++; $display("FAIL bp_cnt%0d got %0d want %0d", d, cnt_out, (d == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 0; out_ready = 4'b0000; in_valid = 1; in_data = 8'h01;
    tick();
    out_ready = 4'b0001; in_data = 8'h02;
    tick();
    out_ready = 4'b0010; in_data = 8'h3C;
    #1;
    n_checks++;
    if (sel !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_setup got sel=%0d ready=%b want 1/1", sel, in_ready);
    end
    tick();
    in_valid = 0; out_ready = 4'b0000;
    n_checks++;
    if (out_valid !== 4'b0100 || out_data !== 8'h3C || sel !== 2'd2) begin
      n_fail++; $display("FAIL b2b_load got valid=%b data=%h sel=%0d want 0100/3c/2", out_valid, out_data, sel);
    end
    out_ready = 4'hF;
    tick();
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = 0; out_ready = 4'hF; in_valid = 1;
    for (int i = 0; i < 3; i++) begin in_data = 8'(i); tick(); end
    in_valid = 0;
    tick();
    out_ready = 4'b0000; in_valid = 1; in_data = 8'h77;
    tick();
    in_valid = 0; mode = 1; in_dest = 0;
    tick();
    n_checks++;
    if (sel !== 2'd3 || out_valid !== 4'b1000 || out_data !== 8'h77) begin
      n_fail++; $display("FAIL mode_hold got sel=%0d valid=%b data=%h want 3/1000/77", sel, out_valid, out_data);
    end
    out_ready = 4'hF;
    tick();
    mode = 0; in_valid = 1; in_data = 8'h55;
    tick();
    in_valid = 0;
    n_checks++;
    if (sel !== 2'd0 || out_valid !== 4'b0001) begin
      n_fail++; $display("FAIL mode_rr_wrap got sel=%0d valid=%b want 0/0001", sel, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1; in_dest = 1; out_ready = 4'hF; in_valid = 1; in_data = 8'h42;
    tick(); tick();
    mode = 0; out_ready = 4'b0000; in_data = 8'h99;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state got valid=%b ready=%b want 0000/1", out_valid, in_ready);
    end
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    for (int d = 0; d < 4; d++) begin
      cnt_sel = 2'(d); #1;
      n_checks++;
      if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt%0d got %0d want 0", d, cnt_out); end
    end
    in_valid = 1; in_data = 8'h12;
    tick();
    in_valid = 0;
    n_checks++;
    if (sel !== 2'd0 || out_valid !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_rr got sel=%0d valid=%b want 0/0001", sel, out_valid);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mode = 1; in_dest = 0; out_ready = 4'hF; in_valid = 1;
    for (int i = 0; i < 5; i++) begin in_data = 8'hC0 + 8'(i); tick(); end
    in_valid = 0;
    tick();
    cnt_sel = 0; #1;
    n_checks++;
    if (cnt_out_s !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2 got %0d want 3", cnt_out_s); end
    n_checks++;
    if (cnt_out !== 8'd5) begin n_fail++; $display("FAIL sat_cnt8 got %0d want 5", cnt_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 2'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cnt_sel   = 2'($urandom);
      #1;
      n_checks++;
      if (out_valid !== exp_valid() || in_ready !== exp_ready() || out_data !== m_data || sel !== 2'(m_sel)) begin
        n_fail++;
        $display("FAIL rand_cyc%0d got valid=%b ready=%b data=%h sel=%0d want %b/%b/%h/%0d", c, out_valid,
                 in_ready, out_data, sel, exp_valid(), exp_ready(), m_data, m_sel);
      end
      n_checks++;
      if (cnt_out !== 8'(m_cnt[cnt_sel]) || cnt_out_s !== 2'(m_cnt2[cnt_sel])) begin
        n_fail++;
        $display("FAIL rand_cnt_cyc%0d idx=%0d got %0d/%0d want %0d/%0d", c, cnt_sel, cnt_out, cnt_out_s,
                 m_cnt[cnt_sel], m_cnt2[cnt_sel]);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_dest = 0; mode = 0; out_ready = 0; cnt_sel = 0;
    m_full = 0; m_sel = 0; m_data = 0; m_rr = 0;
    for (int d = 0; d < 4; d++) begin m_cnt[d] = 0; m_cnt2[d] = 0; end
    test_reset();
    test_rr_stream();
    test_backpressure();
    test_back_to_back();
    test_mode_change();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
